// File: rtl/axi_slv_pkg.sv
// Shared types for the AXI3 memory-backed slave.
// Burst/response encodings and FSM state types.
package axi_slv_pkg;

    typedef enum logic [1:0] {
        FIXED = 2'b00,
        INCR  = 2'b01,
        WRAP  = 2'b10,
        RSVD  = 2'b11
    } burst_e;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_e;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wr_state_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_e;

endpackage

// File: rtl/axi_slv_mem_if.sv
// AXI3 bus bundle between a master and axi_slv_mem.
// All five channels; clock and reset stay outside.
interface axi_slv_mem_if #(
    parameter int ID_W   = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ID_W-1:0]     awid;
    logic [ADDR_W-1:0]   awaddr;
    logic [3:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awbrust;
    logic [1:0]          awlock;
    logic [3:0]          awcache;
    logic [2:0]          awprot;
    logic                awvalid;
    logic                awready;

    logic [ID_W-1:0]     wid;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrob;
    logic                wlast;
    logic                wvalid;
    logic                wready;

    logic [ID_W-1:0]     bid;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    logic [ID_W-1:0]     arid;
    logic [ADDR_W-1:0]   araddr;
    logic [3:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arbrust;
    logic [1:0]          arlock;
    logic [3:0]          arcache;
    logic [2:0]          arprot;
    logic                arvalid;
    logic                arready;

    logic [ID_W-1:0]     rid;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rlast;
    logic                rvalid;
    logic                rready;

    modport master (
        output awid, awaddr, awlen, awsize, awbrust,
        output awlock, awcache, awprot, awvalid,
        input  awready,
        output wid, wdata, wstrob, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arbrust,
        output arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awbrust,
        input  awlock, awcache, awprot, awvalid,
        output awready,
        input  wid, wdata, wstrob, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arbrust,
        input  arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );

endinterface

// File: rtl/axi_slv_addr_gen.sv
// Next beat address and legality of the current beat address.
// Purely combinational; one instance per channel FSM.
module axi_slv_addr_gen
    import axi_slv_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MEM_WORDS = 256
) (
    input  logic [ADDR_W-1:0]            addr,
    input  logic [2:0]                   size,
    input  logic [1:0]                   burst,
    output logic [ADDR_W-1:0]            next_addr,
    output logic [$clog2(MEM_WORDS)-1:0] idx,
    output logic                         ok
);
    localparam int LSB   = $clog2(DATA_W / 8);
    localparam int IDX_W = $clog2(MEM_WORDS);

    logic [ADDR_W-1:0] step;
    logic              sz_ok;
    logic              bu_ok;
    logic              rng_ok;

    assign step   = ADDR_W'(1) << size;
    assign sz_ok  = int'(size) <= LSB;
    assign bu_ok  = (burst == FIXED) || (burst == INCR);
    assign rng_ok = addr[ADDR_W-1:LSB+IDX_W] == '0;
    assign idx    = addr[LSB +: IDX_W];
    assign ok     = sz_ok && bu_ok && rng_ok;

    always_comb begin
        next_addr = addr;
        unique case (1'b1)
            (burst == INCR): next_addr = addr + step;
            default:         next_addr = addr;
        endcase
    end

endmodule

// File: rtl/axi_slv_mem.sv
// AXI3 slave backed by a MEM_WORDS x DATA_W memory.
// Independent write and read FSMs, one burst each.
module axi_slv_mem
    import axi_slv_pkg::*;
#(
    parameter int ID_W      = 4,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MEM_WORDS = 256
) (
    input logic          aclk,
    input logic          arstn,
    axi_slv_mem_if.slave s
);
    localparam int NB    = DATA_W / 8;
    localparam int IDX_W = $clog2(MEM_WORDS);

    logic [DATA_W-1:0] mem [MEM_WORDS];

    // Keeps both ready outputs low until the first edge after reset.
    logic up;

    wr_state_e         w_st;
    logic [ID_W-1:0]   w_id;
    logic [ADDR_W-1:0] w_addr;
    logic [3:0]        w_len;
    logic [3:0]        w_cnt;
    logic [2:0]        w_size;
    logic [1:0]        w_burst;
    logic              w_err;
    logic [1:0]        w_resp;

    logic [ADDR_W-1:0] wg_next;
    logic [IDX_W-1:0]  wg_idx;
    logic              wg_ok;
    logic              w_beat;
    logic              w_end;
    logic              w_err_n;

    rd_state_e         r_st;
    logic [ID_W-1:0]   r_id;
    logic [ADDR_W-1:0] r_addr;
    logic [3:0]        r_len;
    logic [3:0]        r_cnt;
    logic [2:0]        r_size;
    logic [1:0]        r_burst;
    logic [DATA_W-1:0] r_data;
    logic [1:0]        r_resp;
    logic              r_last;

    logic [ADDR_W-1:0] rg_addr;
    logic [2:0]        rg_size;
    logic [1:0]        rg_burst;
    logic [ADDR_W-1:0] rg_next;
    logic [IDX_W-1:0]  rg_idx;
    logic              rg_ok;
    logic [DATA_W-1:0] rd_word;
    logic [1:0]        rd_resp;

    logic unused;
    assign unused = ^{s.wid, s.awlock, s.awcache, s.awprot,
                      s.arlock, s.arcache, s.arprot};

    axi_slv_addr_gen #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .MEM_WORDS (MEM_WORDS)
    ) u_wgen (
        .addr      (w_addr),
        .size      (w_size),
        .burst     (w_burst),
        .next_addr (wg_next),
        .idx       (wg_idx),
        .ok        (wg_ok)
    );

    assign s.awready = up && (w_st == W_IDLE);
    assign s.wready  = (w_st == W_DATA);
    assign s.bvalid  = (w_st == W_RESP);
    assign s.bid     = w_id;
    assign s.bresp   = w_resp;

    assign w_beat  = s.wvalid && s.wready;
    assign w_end   = (w_cnt == w_len);
    assign w_err_n = w_err || !wg_ok || (s.wlast != w_end);

    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            up      <= 1'b0;
            w_st    <= W_IDLE;
            w_id    <= '0;
            w_addr  <= '0;
            w_len   <= '0;
            w_cnt   <= '0;
            w_size  <= '0;
            w_burst <= '0;
            w_err   <= 1'b0;
            w_resp  <= OKAY;
        end else begin
            up <= 1'b1;
            case (w_st)
                W_IDLE: if (s.awvalid && s.awready) begin
                    w_id    <= s.awid;
                    w_addr  <= s.awaddr;
                    w_len   <= s.awlen;
                    w_size  <= s.awsize;
                    w_burst <= s.awbrust;
                    w_cnt   <= '0;
                    w_err   <= 1'b0;
                    w_st    <= W_DATA;
                end
                W_DATA: if (w_beat) begin
                    w_addr <= wg_next;
                    w_cnt  <= w_cnt + 4'd1;
                    w_err  <= w_err_n;
                    if (w_end) begin
                        w_resp <= w_err_n ? SLVERR : OKAY;
                        w_st   <= W_RESP;
                    end
                end
                W_RESP: if (s.bready) w_st <= W_IDLE;
                default: w_st <= W_IDLE;
            endcase
        end
    end

    // Storage is deliberately not reset so contents survive arstn.
    always_ff @(posedge aclk) begin
        if (w_beat && wg_ok) begin
            for (int b = 0; b < NB; b++) begin
                if (s.wstrob[b]) mem[wg_idx][8*b +: 8] <= s.wdata[8*b +: 8];
            end
        end
    end

    // In idle the generator checks the incoming AR address, later the
    // address of the beat to be fetched next.
    assign rg_addr  = (r_st == R_IDLE) ? s.araddr  : r_addr;
    assign rg_size  = (r_st == R_IDLE) ? s.arsize  : r_size;
    assign rg_burst = (r_st == R_IDLE) ? s.arbrust : r_burst;

    axi_slv_addr_gen #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .MEM_WORDS (MEM_WORDS)
    ) u_rgen (
        .addr      (rg_addr),
        .size      (rg_size),
        .burst     (rg_burst),
        .next_addr (rg_next),
        .idx       (rg_idx),
        .ok        (rg_ok)
    );

    assign rd_word = rg_ok ? mem[rg_idx] : '0;
    assign rd_resp = rg_ok ? OKAY : SLVERR;

    assign s.arready = up && (r_st == R_IDLE);
    assign s.rvalid  = (r_st == R_DATA);
    assign s.rid     = r_id;
    assign s.rdata   = r_data;
    assign s.rresp   = r_resp;
    assign s.rlast   = r_last;

    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            r_st    <= R_IDLE;
            r_id    <= '0;
            r_addr  <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_size  <= '0;
            r_burst <= '0;
            r_data  <= '0;
            r_resp  <= OKAY;
            r_last  <= 1'b0;
        end else begin
            case (r_st)
                R_IDLE: if (s.arvalid && s.arready) begin
                    r_id    <= s.arid;
                    r_len   <= s.arlen;
                    r_size  <= s.arsize;
                    r_burst <= s.arbrust;
                    r_cnt   <= '0;
                    r_addr  <= rg_next;
                    r_data  <= rd_word;
                    r_resp  <= rd_resp;
                    r_last  <= (s.arlen == 4'd0);
                    r_st    <= R_DATA;
                end
                R_DATA: if (s.rready) begin
                    if (r_last) begin
                        r_last <= 1'b0;
                        r_st   <= R_IDLE;
                    end else begin
                        r_cnt  <= r_cnt + 4'd1;
                        r_addr <= rg_next;
                        r_data <= rd_word;
                        r_resp <= rd_resp;
                        r_last <= (r_cnt + 4'd1 == r_len);
                    end
                end
                default: r_st <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_slv_mem.sv
// Directed bench for axi_slv_mem with a byte-level memory model
// and a per-cycle R/B channel checker.
module tb_axi_slv_mem;

    logic aclk;
    logic arstn;

    axi_slv_mem_if #(.ID_W(4), .ADDR_W(32), .DATA_W(32)) bus ();

    axi_slv_mem #(
        .ID_W      (4),
        .ADDR_W    (32),
        .DATA_W    (32),
        .MEM_WORDS (256)
    ) dut (
        .aclk  (aclk),
        .arstn (arstn),
        .s     (bus)
    );

    typedef struct {
        logic [3:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } rbeat_t;

    typedef struct {
        logic [3:0] id;
        logic [1:0] resp;
    } bexp_t;

    rbeat_t      rq [$];
    bexp_t       bq [$];
    logic [31:0] rd_log [$];
    logic [31:0] mm [256];
    logic [31:0] wd [16];
    logic [3:0]  ws [16];
    logic        wl [16];

    int tests = 0;
    int fails = 0;

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic bit legal(input logic [31:0] a, input logic [2:0] sz,
                                 input logic [1:0] bu);
        return (bu == 2'b00 || bu == 2'b01) && sz <= 3'd2 && a < 32'h400;
    endfunction

    function automatic logic [31:0] adv(input logic [31:0] a,
                                        input logic [2:0] sz,
                                        input logic [1:0] bu);
        return (bu == 2'b01) ? a + (32'd1 << sz) : a;
    endfunction

    // Per-cycle checker: every valid R/B cycle must match the queue head.
    initial begin
        forever begin
            @(negedge aclk);
            if (arstn) begin
                if (bus.rvalid) begin
                    if (rq.size() == 0) begin
                        chk("r_unexpected", bus.rvalid, 0);
                    end else begin
                        chk("rid", bus.rid, rq[0].id);
                        chk("rdata", bus.rdata, rq[0].data);
                        chk("rresp", bus.rresp, rq[0].resp);
                        chk("rlast", bus.rlast, rq[0].last);
                        if (bus.rready) begin
                            rd_log.push_back(bus.rdata);
                            void'(rq.pop_front());
                        end
                    end
                end
                if (bus.bvalid) begin
                    if (bq.size() == 0) begin
                        chk("b_unexpected", bus.bvalid, 0);
                    end else begin
                        chk("bid", bus.bid, bq[0].id);
                        chk("bresp", bus.bresp, bq[0].resp);
                        if (bus.bready) void'(bq.pop_front());
                    end
                end
            end
        end
    end

    task automatic reset_pulse();
        arstn = 1'b0;
        bus.awvalid = 0;
        bus.wvalid  = 0;
        bus.wlast   = 0;
        bus.bready  = 0;
        bus.arvalid = 0;
        bus.rready  = 0;
        @(negedge aclk);
        chk("rst_awready", bus.awready, 0);
        chk("rst_wready", bus.wready, 0);
        chk("rst_bvalid", bus.bvalid, 0);
        chk("rst_arready", bus.arready, 0);
        chk("rst_rvalid", bus.rvalid, 0);
        chk("rst_rlast", bus.rlast, 0);
        chk("rst_bid", bus.bid, 0);
        chk("rst_rid", bus.rid, 0);
        chk("rst_bresp", bus.bresp, 0);
        chk("rst_rresp", bus.rresp, 0);
        chk("rst_rdata", bus.rdata, 0);
        @(negedge aclk);
        arstn = 1'b1;
        chk("pre_edge_awready", bus.awready, 0);
        @(posedge aclk);
        #1;
        chk("post_rst_awready", bus.awready, 1);
        chk("post_rst_arready", bus.arready, 1);
        chk("post_rst_bvalid", bus.bvalid, 0);
    endtask

    task automatic set_beats(input logic [31:0] base, input int n);
        for (int i = 0; i < 16; i++) begin
            wd[i] = base + 32'(i);
            ws[i] = 4'hF;
            wl[i] = (i == n - 1);
        end
    endtask

    task automatic do_write(input logic [3:0] id, input logic [31:0] addr,
                            input logic [3:0] len, input logic [2:0] size,
                            input logic [1:0] burst, input bit early_w,
                            input int abort_at);
        logic [31:0] a;
        bit err;
        bit ok;
        int cyc;
        a = addr;
        err = 0;
        if (early_w) begin
            bus.wvalid = 1;
            bus.wdata  = wd[0];
            bus.wstrob = ws[0];
            bus.wlast  = wl[0];
            repeat (3) begin
                @(negedge aclk);
                chk("w_before_aw_wready", bus.wready, 0);
                @(posedge aclk);
                #1;
            end
        end
        bus.awid    = id;
        bus.awaddr  = addr;
        bus.awlen   = len;
        bus.awsize  = size;
        bus.awbrust = burst;
        bus.awvalid = 1;
        ok = 0;
        cyc = 0;
        while (!ok && cyc < 50) begin
            @(negedge aclk);
            if (bus.awready) ok = 1;
            @(posedge aclk);
            #1;
            cyc++;
        end
        chk("aw_handshake", ok, 1);
        bus.awvalid = 0;
        for (int i = 0; i <= int'(len); i++) begin
            if (i == abort_at) begin
                reset_pulse();
                return;
            end
            bus.wvalid = 1;
            bus.wdata  = wd[i];
            bus.wstrob = ws[i];
            bus.wlast  = wl[i];
            ok = 0;
            cyc = 0;
            while (!ok && cyc < 50) begin
                @(negedge aclk);
                if (bus.wready) ok = 1;
                @(posedge aclk);
                #1;
                cyc++;
            end
            chk("w_handshake", ok, 1);
            if (legal(a, size, burst)) begin
                for (int b = 0; b < 4; b++) begin
                    if (ws[i][b]) mm[a[9:2]][8*b +: 8] = wd[i][8*b +: 8];
                end
            end else begin
                err = 1;
            end
            if (wl[i] != (i == int'(len))) err = 1;
            a = adv(a, size, burst);
        end
        bus.wvalid = 0;
        bus.wlast  = 0;
        bq.push_back('{id: id, resp: err ? 2'b10 : 2'b00});
        repeat (2) begin
            @(posedge aclk);
            #1;
        end
        bus.bready = 1;
        cyc = 0;
        while (bq.size() != 0 && cyc < 50) begin
            @(negedge aclk);
            cyc++;
        end
        @(posedge aclk);
        #1;
        bus.bready = 0;
        chk("b_done", bq.size(), 0);
    endtask

    task automatic do_read(input logic [3:0] id, input logic [31:0] addr,
                           input logic [3:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input int stall_beat,
                           input int stall_len);
        logic [31:0] a;
        bit ok;
        int cyc;
        int n;
        int st;
        a = addr;
        rd_log.delete();
        for (int i = 0; i <= int'(len); i++) begin
            rq.push_back('{id: id,
                           data: legal(a, size, burst) ? mm[a[9:2]] : 32'h0,
                           resp: legal(a, size, burst) ? 2'b00 : 2'b10,
                           last: (i == int'(len))});
            a = adv(a, size, burst);
        end
        bus.arid    = id;
        bus.araddr  = addr;
        bus.arlen   = len;
        bus.arsize  = size;
        bus.arbrust = burst;
        bus.arvalid = 1;
        ok = 0;
        cyc = 0;
        while (!ok && cyc < 50) begin
            @(negedge aclk);
            if (bus.arready) ok = 1;
            @(posedge aclk);
            #1;
            cyc++;
        end
        chk("ar_handshake", ok, 1);
        bus.arvalid = 0;
        n = 0;
        st = 0;
        cyc = 0;
        while (n <= int'(len) && cyc < 100) begin
            bus.rready = !(n == stall_beat && st < stall_len);
            @(negedge aclk);
            if (bus.rvalid && bus.rready) n++;
            else if (bus.rvalid) st++;
            @(posedge aclk);
            #1;
            cyc++;
        end
        bus.rready = 0;
        chk("r_beats", n, int'(len) + 1);
        chk("r_stall_cycles", st, stall_len);
    endtask

    initial begin
        arstn = 1'b0;
        bus.awid = 0; bus.awaddr = 0; bus.awlen = 0; bus.awsize = 0;
        bus.awbrust = 0; bus.awlock = 0; bus.awcache = 0; bus.awprot = 0;
        bus.awvalid = 0;
        bus.wid = 0; bus.wdata = 0; bus.wstrob = 0; bus.wlast = 0;
        bus.wvalid = 0; bus.bready = 0;
        bus.arid = 0; bus.araddr = 0; bus.arlen = 0; bus.arsize = 0;
        bus.arbrust = 0; bus.arlock = 0; bus.arcache = 0; bus.arprot = 0;
        bus.arvalid = 0; bus.rready = 0;
        for (int i = 0; i < 256; i++) mm[i] = 32'h0;

        reset_pulse();

        set_beats(32'hA0, 4);
        do_write(4'h5, 32'h10, 4'd3, 3'd2, 2'b01, 1, -1);
        chk("model_w4", mm[4], 32'hA0);
        chk("model_w7", mm[7], 32'hA3);
        do_read(4'h9, 32'h10, 4'd3, 3'd2, 2'b01, -1, 0);
        chk("rd_incr0", rd_log[0], 32'hA0);
        chk("rd_incr3", rd_log[3], 32'hA3);

        set_beats(32'h12345678, 1);
        do_write(4'h1, 32'h40, 4'd0, 3'd2, 2'b01, 0, -1);
        set_beats(32'hFFFFFFFF, 1);
        ws[0] = 4'b0101;
        do_write(4'h2, 32'h40, 4'd0, 3'd2, 2'b01, 0, -1);
        do_read(4'h3, 32'h40, 4'd0, 3'd2, 2'b01, -1, 0);
        chk("rd_strobe", rd_log[0], 32'h12FF56FF);

        set_beats(32'hC0, 4);
        wl[3] = 0;
        wl[2] = 1;
        do_write(4'h6, 32'h80, 4'd3, 3'd2, 2'b01, 0, -1);

        set_beats(32'hDEADBEEF, 2);
        do_write(4'h7, 32'h40, 4'd1, 3'd2, 2'b10, 0, -1);
        do_read(4'h8, 32'h40, 4'd0, 3'd2, 2'b01, -1, 0);
        chk("rd_after_wrap", rd_log[0], 32'h12FF56FF);
        do_read(4'hA, 32'h40, 4'd1, 3'd2, 2'b10, -1, 0);
        chk("rd_wrap_zero", rd_log[1], 32'h0);

        do_read(4'hB, 32'h10, 4'd3, 3'd2, 2'b01, 1, 3);
        chk("rd_stall1", rd_log[1], 32'hA1);
        chk("rd_stall2", rd_log[2], 32'hA2);

        do_read(4'hC, 32'h400, 4'd0, 3'd2, 2'b01, -1, 0);
        do_read(4'hD, 32'h10, 4'd0, 3'd3, 2'b01, -1, 0);

        set_beats(32'h1, 3);
        do_write(4'hE, 32'hC0, 4'd2, 3'd2, 2'b00, 0, -1);
        do_read(4'hF, 32'hC0, 4'd1, 3'd2, 2'b00, -1, 0);
        chk("rd_fixed", rd_log[1], 32'h3);

        set_beats(32'hB0, 4);
        do_write(4'h3, 32'h10, 4'd3, 3'd2, 2'b01, 0, 2);
        do_read(4'h4, 32'h10, 4'd3, 3'd2, 2'b01, -1, 0);
        chk("rd_rst_b0", rd_log[0], 32'hB0);
        chk("rd_rst_b1", rd_log[1], 32'hB1);
        chk("rd_rst_keep2", rd_log[2], 32'hA2);
        chk("rd_rst_keep3", rd_log[3], 32'hA3);

        repeat (3) @(posedge aclk);
        chk("rq_empty", rq.size(), 0);
        chk("bq_empty", bq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
